nano_mem: RTL and testbench

Memory and I/O responder for the `nano` core. It owns the 256×8 instruction memory and the 64×8 data memory that answer the core's fetch and load/store ports. It also owns a byte-stream program loader that fills instruction memory while holding the core in reset. Data address `IO_ADDR` is a memory-mapped I/O port.

---
 rtl/nano_pkg.sv | 12 +
 rtl/nano_loader.sv | 61 ++++++
 rtl/nano_mem.sv | 105 ++++++++++
 tb/tb_nano_mem.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/nano_pkg.sv
// Shared types and constants for the nano memory/I-O responder.
package nano_pkg;

  typedef enum logic {
    LOAD = 1'b0,
    RUN  = 1'b1
  } loader_state_e;

  localparam int         IMEM_WORDS      = 256;
  localparam logic [7:0] IO_ADDR_DEFAULT = 8'h3F;

endpackage

// File: rtl/nano_loader.sv
// Byte-stream program loader: owns the LOAD/RUN FSM, the imem write pointer
// and the sticky overflow flag, and holds the core in reset while loading.
module nano_loader
  import nano_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       load_valid_i,
  input  logic [7:0] load_data_i,
  input  logic       load_last_i,
  output logic       load_ready_o,
  output logic       load_overflow_o,
  output logic       core_reset_o,
  output logic       imem_we_o,
  output logic [7:0] imem_waddr_o,
  output logic [7:0] imem_wdata_o
);

  loader_state_e state_q, state_d;
  logic [7:0]    ptr_q, ptr_d;
  logic          ovf_q, ovf_d;
  logic          accept;

  assign accept = load_valid_i & (state_q == LOAD);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= LOAD;
      ptr_q   <= 8'h00;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      ovf_q   <= ovf_d;
    end
  end

  // A last byte that also wraps the pointer both flags overflow and enters RUN.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    ovf_d   = ovf_q;
    if (accept) begin
      ptr_d = ptr_q + 8'h01;
      if (ptr_q == 8'hFF) begin
        ovf_d = 1'b1;
      end
      if (load_last_i) begin
        state_d = RUN;
      end
    end
  end

  assign load_ready_o    = (state_q == LOAD);
  assign core_reset_o    = (state_q == LOAD);
  assign load_overflow_o = ovf_q;
  assign imem_we_o       = accept;
  assign imem_waddr_o    = ptr_q;
  assign imem_wdata_o    = load_data_i;

endmodule

// File: rtl/nano_mem.sv
// Instruction/data memories, data address decode and memory-mapped I/O port
// for the nano core; program loading is delegated to nano_loader.
module nano_mem
  import nano_pkg::*;
#(
  parameter int         DMEM_WORDS = 64,
  parameter logic [7:0] IO_ADDR    = IO_ADDR_DEFAULT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] instr_addr,
  output logic [7:0] instr,
  input  logic [7:0] data_addr,
  input  logic [7:0] data_out,
  input  logic       data_we,
  output logic [7:0] data_in,
  input  logic       load_valid,
  input  logic [7:0] load_data,
  input  logic       load_last,
  output logic       load_ready,
  output logic       load_overflow,
  output logic       core_reset,
  input  logic [7:0] io_in,
  output logic [7:0] io_out,
  output logic       io_strobe
);

  localparam int DAW = (DMEM_WORDS > 1) ? $clog2(DMEM_WORDS) : 1;

  logic [7:0] imem [IMEM_WORDS];
  logic [7:0] dmem [DMEM_WORDS];

  logic       imem_we;
  logic [7:0] imem_waddr, imem_wdata;
  logic       isIo, inDmem, storeIo, storeRam;
  logic [7:0] io_out_q, io_out_d;
  logic       io_strobe_q, io_strobe_d;
  logic [7:0] sync1_q, sync2_q;

  nano_loader u_loader (
    .clk             (clk),
    .reset           (reset),
    .load_valid_i    (load_valid),
    .load_data_i     (load_data),
    .load_last_i     (load_last),
    .load_ready_o    (load_ready),
    .load_overflow_o (load_overflow),
    .core_reset_o    (core_reset),
    .imem_we_o       (imem_we),
    .imem_waddr_o    (imem_waddr),
    .imem_wdata_o    (imem_wdata)
  );

  // Stores are gated by core_reset: the core runs garbage while held in LOAD.
  assign isIo     = (data_addr == IO_ADDR);
  assign inDmem   = (int'(data_addr) < DMEM_WORDS);
  assign storeIo  = ~core_reset & data_we & isIo;
  assign storeRam = ~core_reset & data_we & ~isIo & inDmem;

  always_ff @(posedge clk) begin
    if (imem_we) begin
      imem[imem_waddr] <= imem_wdata;
    end
    if (storeRam) begin
      dmem[data_addr[DAW-1:0]] <= data_out;
    end
  end

  always_comb begin
    io_out_d    = io_out_q;
    io_strobe_d = storeIo;
    if (storeIo) begin
      io_out_d = data_out;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      io_out_q    <= 8'h00;
      io_strobe_q <= 1'b0;
      sync1_q     <= 8'h00;
      sync2_q     <= 8'h00;
    end else begin
      io_out_q    <= io_out_d;
      io_strobe_q <= io_strobe_d;
      sync1_q     <= io_in;
      sync2_q     <= sync1_q;
    end
  end

  assign instr = imem[instr_addr];

  always_comb begin
    data_in = 8'h00;
    if (isIo) begin
      data_in = sync2_q;
    end else if (inDmem) begin
      data_in = dmem[data_addr[DAW-1:0]];
    end
  end

  assign io_out    = io_out_q;
  assign io_strobe = io_strobe_q;

endmodule

// File: tb/tb_nano_mem.sv
// Directed self-checking bench for nano_mem: expected values are queued on a
// scoreboard as stimulus is driven and popped when the DUT output is sampled.
module tb_nano_mem;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] instr_addr;
  logic [7:0] instr;
  logic [7:0] data_addr;
  logic [7:0] data_out;
  logic       data_we;
  logic [7:0] data_in;
  logic       load_valid;
  logic [7:0] load_data;
  logic       load_last;
  logic       load_ready;
  logic       load_overflow;
  logic       core_reset;
  logic [7:0] io_in;
  logic [7:0] io_out;
  logic       io_strobe;

  typedef struct {
    string      tag;
    logic [7:0] val;
  } exp_t;

  exp_t sbq[$];
  int   passCount  = 0;
  int   failCount  = 0;
  int   totalCount = 0;

  nano_mem dut (
    .clk           (clk),
    .reset         (reset),
    .instr_addr    (instr_addr),
    .instr         (instr),
    .data_addr     (data_addr),
    .data_out      (data_out),
    .data_we       (data_we),
    .data_in       (data_in),
    .load_valid    (load_valid),
    .load_data     (load_data),
    .load_last     (load_last),
    .load_ready    (load_ready),
    .load_overflow (load_overflow),
    .core_reset    (core_reset),
    .io_in         (io_in),
    .io_out        (io_out),
    .io_strobe     (io_strobe)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pushExpect(input string tag, input logic [7:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    sbq.push_back(e);
  endtask

  task automatic checkOutput(input logic [7:0] observed);
    exp_t e;
    totalCount++;
    if (sbq.size() == 0) begin
      failCount++;
      $error("[TB] FAIL scoreboard_empty: observed %h, required an entry", observed);
      return;
    end
    e = sbq.pop_front();
    assert (observed === e.val) passCount++;
    else begin
      failCount++;
      $error("[TB] FAIL %s: observed %h, required %h", e.tag, observed, e.val);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] addr, input logic [7:0] wdata, input logic we);
    data_addr = addr;
    data_out  = wdata;
    data_we   = we;
  endtask

  task automatic loadByte(input logic [7:0] b, input logic last);
    load_valid = 1'b1;
    load_data  = b;
    load_last  = last;
    tick();
    load_valid = 1'b0;
    load_last  = 1'b0;
  endtask

  initial begin
    reset      = 1'b1;
    instr_addr = 8'h00;
    load_valid = 1'b0;
    load_data  = 8'h00;
    load_last  = 1'b0;
    io_in      = 8'h00;
    applyStimulus(8'h00, 8'h00, 1'b0);
    tick();
    tick();
    reset = 1'b0;
    tick();

    // Reset state
    pushExpect("rst_load_ready", 8'h01);    checkOutput({7'b0, load_ready});
    pushExpect("rst_core_reset", 8'h01);    checkOutput({7'b0, core_reset});
    pushExpect("rst_overflow", 8'h00);      checkOutput({7'b0, load_overflow});
    pushExpect("rst_io_out", 8'h00);        checkOutput(io_out);
    pushExpect("rst_io_strobe", 8'h00);     checkOutput({7'b0, io_strobe});

    // Three-byte program; control outputs fall on the third accept edge
    loadByte(8'h11, 1'b0);
    loadByte(8'h22, 1'b0);
    pushExpect("pre_last_core_reset", 8'h01); checkOutput({7'b0, core_reset});
    loadByte(8'h33, 1'b1);
    pushExpect("run_core_reset", 8'h00);    checkOutput({7'b0, core_reset});
    pushExpect("run_load_ready", 8'h00);    checkOutput({7'b0, load_ready});
    instr_addr = 8'h00; #1;
    pushExpect("imem0", 8'h11);             checkOutput(instr);
    instr_addr = 8'h01; #1;
    pushExpect("imem1", 8'h22);             checkOutput(instr);
    instr_addr = 8'h02; #1;
    pushExpect("imem2", 8'h33);             checkOutput(instr);

    // load_valid is ignored in RUN
    loadByte(8'h99, 1'b0);
    pushExpect("run_ignores_load", 8'h00);  checkOutput({7'b0, load_ready});

    // RAM stores and out-of-range drops
    applyStimulus(8'h05, 8'hA5, 1'b1); pushExpect("dmem5", 8'hA5); tick();
    applyStimulus(8'h3E, 8'h6E, 1'b1); pushExpect("dmem3e", 8'h6E); tick();
    applyStimulus(8'h80, 8'h77, 1'b1); pushExpect("rd80", 8'h00); tick();
    applyStimulus(8'h40, 8'h44, 1'b1); pushExpect("rd40", 8'h00); tick();
    applyStimulus(8'h05, 8'h00, 1'b0); #1; checkOutput(data_in);
    applyStimulus(8'h3E, 8'h00, 1'b0); #1; checkOutput(data_in);
    applyStimulus(8'h80, 8'h00, 1'b0); #1; checkOutput(data_in);
    applyStimulus(8'h40, 8'h00, 1'b0); #1; checkOutput(data_in);

    // I/O store: single pulse, then back-to-back pulses
    applyStimulus(8'h3F, 8'h5A, 1'b1);
    tick();
    applyStimulus(8'h3F, 8'h00, 1'b0);
    pushExpect("io_out_5a", 8'h5A);         checkOutput(io_out);
    pushExpect("io_strobe_hi", 8'h01);      checkOutput({7'b0, io_strobe});
    tick();
    pushExpect("io_strobe_lo", 8'h00);      checkOutput({7'b0, io_strobe});
    applyStimulus(8'h3F, 8'h12, 1'b1);
    tick();
    applyStimulus(8'h3F, 8'h34, 1'b1);
    pushExpect("b2b_strobe1", 8'h01);       checkOutput({7'b0, io_strobe});
    tick();
    applyStimulus(8'h3F, 8'h00, 1'b0);
    pushExpect("b2b_strobe2", 8'h01);       checkOutput({7'b0, io_strobe});
    pushExpect("b2b_io_out", 8'h34);        checkOutput(io_out);
    applyStimulus(8'h05, 8'h00, 1'b0); #1;
    pushExpect("dmem5_after_io", 8'hA5);    checkOutput(data_in);

    // io_in synchronizer latency
    applyStimulus(8'h3F, 8'h00, 1'b0);
    io_in = 8'hC3;
    tick();
    pushExpect("io_in_1edge", 8'h00);       checkOutput(data_in);
    tick();
    pushExpect("io_in_2edge", 8'hC3);       checkOutput(data_in);

    // Async reset from RUN, then stores while in LOAD must be ignored
    reset = 1'b1; #1;
    pushExpect("async_core_reset", 8'h01);  checkOutput({7'b0, core_reset});
    reset = 1'b0;
    tick();
    applyStimulus(8'h05, 8'hFF, 1'b1);
    tick();
    applyStimulus(8'h3F, 8'hEE, 1'b1);
    tick();
    pushExpect("load_store_strobe", 8'h00); checkOutput({7'b0, io_strobe});
    pushExpect("load_store_io_out", 8'h00); checkOutput(io_out);
    applyStimulus(8'h05, 8'h00, 1'b0); #1;
    pushExpect("load_store_dmem5", 8'hA5);  checkOutput(data_in);

    // 257-byte stream: overflow on the 256th, 257th overwrites imem[0]
    for (int i = 0; i < 256; i++) begin
      loadByte(8'(i) ^ 8'h5A, 1'b0);
    end
    pushExpect("ovf_set", 8'h01);           checkOutput({7'b0, load_overflow});
    pushExpect("ovf_still_load", 8'h01);    checkOutput({7'b0, core_reset});
    loadByte(8'hE7, 1'b1);
    pushExpect("ovf_run", 8'h00);           checkOutput({7'b0, core_reset});
    pushExpect("ovf_sticky", 8'h01);        checkOutput({7'b0, load_overflow});
    instr_addr = 8'h00; #1;
    pushExpect("ovf_imem0", 8'hE7);         checkOutput(instr);
    instr_addr = 8'h01; #1;
    pushExpect("ovf_imem1", 8'h5B);         checkOutput(instr);
    instr_addr = 8'hFF; #1;
    pushExpect("ovf_imemff", 8'hA5);        checkOutput(instr);

    // Async reset clears overflow; mid-load reset restarts ptr at 0
    reset = 1'b1; #1;
    pushExpect("rst_ovf_clear", 8'h00);     checkOutput({7'b0, load_overflow});
    pushExpect("rst2_core_reset", 8'h01);   checkOutput({7'b0, core_reset});
    reset = 1'b0;
    tick();
    loadByte(8'hC1, 1'b0);
    loadByte(8'hC2, 1'b0);
    #2;
    reset = 1'b1; #1;
    pushExpect("midload_core_reset", 8'h01); checkOutput({7'b0, core_reset});
    reset = 1'b0;
    tick();
    loadByte(8'hD1, 1'b1);
    instr_addr = 8'h00; #1;
    pushExpect("reload_imem0", 8'hD1);      checkOutput(instr);
    instr_addr = 8'h01; #1;
    pushExpect("reload_imem1", 8'hC2);      checkOutput(instr);
    pushExpect("reload_run", 8'h00);        checkOutput({7'b0, core_reset});
    pushExpect("reload_no_ovf", 8'h00);     checkOutput({7'b0, load_overflow});

    if (sbq.size() != 0) begin
      totalCount++;
      failCount++;
      $error("[TB] FAIL scoreboard_leftover: observed %0d entries, required 0", sbq.size());
    end

    $display("%0d/%0d checks passed", passCount, totalCount);
    $finish;
  end

endmodule
